// File: rtl/stdin_rx.sv
// stdin_rx: 8N1 UART receiver feeding a first-word-fall-through byte FIFO
// that supplies the core's ',' instruction through a valid/ack pop handshake.
module stdin_rx #(
    parameter int BAUD    = 104,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               rx,
    output logic [7:0]         data,
    output logic               valid,
    input  logic               ack,
    output logic [FIFO_AW:0]   level,
    output logic               frame_err,
    output logic               overrun
);

    localparam int                CW         = $clog2(BAUD);
    localparam int                DEPTH      = 2 ** FIFO_AW;
    localparam logic [CW-1:0]     CNT_HALF   = CW'(BAUD / 2);
    localparam logic [CW-1:0]     CNT_RELOAD = CW'(BAUD - 1);
    localparam logic [CW-1:0]     CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
    localparam logic [FIFO_AW:0]  PTR_ZERO   = {(FIFO_AW + 1){1'b0}};
    localparam logic [FIFO_AW:0]  PTR_ONE    = (FIFO_AW + 1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                r_sync1;
    logic                r_sync2;
    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_frame_err;
    logic                r_overrun;
    logic [FIFO_AW:0]    r_wr_ptr;
    logic [FIFO_AW:0]    r_rd_ptr;
    logic [7:0]          r_mem [DEPTH];

    logic [1:0]          w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_tick;
    logic                w_stop_sample;
    logic                w_push;
    logic                w_bad_stop;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_wr_en;
    logic                w_drop;

    // Two-flop synchroniser; resets to idle-high so a low line after reset looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick        = (r_cnt == CNT_ZERO);
    assign w_stop_sample = (r_state == S_STOP) && w_tick;
    assign w_push        = w_stop_sample && r_sync2;
    assign w_bad_stop    = w_stop_sample && !r_sync2;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_pop   = ack && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Receive FSM next-state: mid-bit sampling paced by the down-counting sample counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (!r_sync2) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = CNT_HALF;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_sync2) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = CNT_RELOAD;
                        w_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_cnt_nxt   = CNT_RELOAD;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_STOP: begin
                // Leave on the stop sample so a new start edge in the stop bit's second half is caught.
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_RELOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Receive FSM state, counters and shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Error pulses, registered so each lasts exactly one cycle after the stop sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_overrun   <= w_drop;
        end
    end

    // FIFO pointers; one extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_shift;
        end
    end

    assign data      = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign valid     = !w_empty;
    assign level     = r_wr_ptr - r_rd_ptr;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: doc/stdin_rx.md
Name: stdin_rx

Overview:
UART receiver with a byte FIFO that feeds stdin to the brainfuck core's ',' instruction. It is the receive-side counterpart of uart_tx and drives the top-level uart_rx_pin path.
- Deserialises 8N1 frames on rx.
- Buffers complete bytes in a first-word-fall-through FIFO.
- Presents the FIFO head to the core with a valid/ack pop handshake.
- Runs on the system clock clk, not cpu_clk.

Parameters:
BAUD, 104, clock cycles per bit (12 MHz / 115200); must be >= 4; same value set as uart_tx BAUD.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.

Ports:
clk  input  1  system clock; all logic on posedge.
rstn  input  1  asynchronous active-low reset.
rx  input  1  serial input, asynchronous to clk, idle high.
data  output  8  FIFO head byte; don't-care while valid=0.
valid  output  1  FIFO non-empty.
ack  input  1  pop request; honoured only when valid=1.
level  output  FIFO_AW+1  bytes held, 0..2**FIFO_AW.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: completed byte dropped because FIFO full.

Behaviour:
- Reset (rstn low, async): FSM=IDLE; both synchroniser flops=1; bit counter, sample counter, rd/wr pointers=0. Outputs: valid=0, level=0, frame_err=0, overrun=0.
- rx passes through a 2-flop synchroniser; rxs = second flop. All sampling uses rxs.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on rxs==0 (first cycle seen low = t0), go to START and load the sample counter with BAUD/2 (integer divide).
- START: at t0+BAUD/2, sample rxs.
  - rxs==1: glitch; return to IDLE, no output.
  - rxs==0: go to DATA.
- DATA: sample bit i (i=0..7, LSB first) at t0+BAUD/2+(i+1)*BAUD into a shift register; after bit 7 go to STOP.
- STOP: sample at t0+BAUD/2+9*BAUD.
  - rxs==1: byte is written to FIFO on that clock edge.
  - rxs==0: frame_err pulses for exactly the next cycle; byte discarded.
  - Either case: return to IDLE on the same edge so the next start edge is detectable in the second half of the stop bit.
- Sample counter width $clog2(BAUD); it counts down and reloads BAUD-1 at each sample.
- FIFO write latency: stop sample at edge S writes the byte; valid=1, data=byte, level incremented are visible from S+1.
- Pop: at posedge with ack=1 and valid=1, the rd pointer advances and level decrements. ack with valid=0 is ignored (no underflow, level stays 0).
- Push when full with no pop: byte dropped; overrun pulses one cycle; FIFO contents and level unchanged.
- Push and pop on the same edge:
  - Not full: both occur; level unchanged.
  - Full: both occur, byte accepted, no overrun.
- Pointers are FIFO_AW+1 bits and wrap naturally.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - level = wr - rd, modulo 2**(FIFO_AW+1).
- data is combinational from the storage array at rd pointer (FWFT); no extra read latency.
- Reset mid-frame: partial byte lost, FIFO emptied.
  - After release, a low rx is treated as a start edge, because the synchroniser resets to 1.
  - A frame in progress therefore either fails validation (START glitch or frame_err) or is received as whatever bits are sampled.
- frame_err and overrun never pulse on the same cycle; a frame_err byte never reaches the FIFO.

Test Plan:
- BAUD=8. Send 8N1 frame 0x41 -> valid rises exactly 1 cycle after the stop sample (t0+76); data=0x41, level=1. Pulse ack once -> valid=0, level=0.
- Drive rx low for 2 cycles then high -> FSM returns to IDLE at mid-start; valid stays 0; no frame_err.
- Send 0x5A with stop bit low -> frame_err one-cycle pulse; level stays 0. A following good frame 0x33 is received correctly.
- Send 17 bytes 0x00..0x10 with no ack -> level=16; overrun pulses on the 17th; draining with ack yields 0x00..0x0F in order, then valid=0.
- FIFO full, ack held high as the 17th byte's stop is sampled -> no overrun; level stays 16; the last byte read out is 0x10.
- Assert rstn low mid-DATA, release, then send 0xC3 -> level=0 immediately after reset; subsequently data=0xC3 with level=1.
